// File: rtl/multi_queue_dispatcher_pkg.sv
// rtl/multi_queue_dispatcher_pkg.sv - shared types, opcodes and decode helpers for the dispatcher
package multi_queue_dispatcher_pkg;

  localparam int NUM_Q = 4;
  // Tag field in a queue entry; the TAG_W-bit counter is zero-extended into it (TAG_W <= 8).
  localparam int TAG_FIELD_W = 8;

  typedef enum logic [1:0] {
    Q_INT   = 2'd0,
    Q_LD_ST = 2'd1,
    Q_MULT  = 2'd2,
    Q_DIV   = 2'd3
  } q_sel_t;

  typedef struct packed {
    logic [TAG_FIELD_W-1:0] tag;
    logic [31:0]            pc;
    logic [31:0]            instr;
  } disp_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_JMP_WAIT
  } disp_state_t;

  typedef struct packed {
    logic   illegal;
    q_sel_t q;
  } disp_class_t;

  localparam logic [6:0] OP_REG        = 7'b0110011;
  localparam logic [6:0] OP_IMM        = 7'b0010011;
  localparam logic [6:0] OP_LUI        = 7'b0110111;
  localparam logic [6:0] OP_AUIPC      = 7'b0010111;
  localparam logic [6:0] OP_BRANCH     = 7'b1100011;
  localparam logic [6:0] OP_JAL        = 7'b1101111;
  localparam logic [6:0] OP_JALR       = 7'b1100111;
  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_STORE      = 7'b0100011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Maps an instruction to its issue queue; funct3[2] splits the M extension into mul/div.
  function automatic disp_class_t decode_class(input logic [31:0] instr);
    disp_class_t c;
    c.illegal = 1'b0;
    c.q       = Q_INT;
    case (instr[6:0])
      OP_REG: begin
        if (instr[31:25] == FUNCT7_MULDIV) c.q = instr[14] ? Q_DIV : Q_MULT;
      end
      OP_IMM, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: c.q = Q_INT;
      OP_LOAD, OP_STORE: c.q = Q_LD_ST;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Sign-extended J-type immediate.
  function automatic logic [31:0] jal_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/multi_queue_dispatcher_if.sv
// rtl/multi_queue_dispatcher_if.sv - issue-queue read side shared by dispatcher and consumers
interface multi_queue_dispatcher_if
  import multi_queue_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_Q-1:0] i_q_rd_en;
  logic [NUM_Q-1:0] o_q_valid;
  disp_entry_t      o_q_data  [NUM_Q];
  logic [CW-1:0]    o_q_count [NUM_Q];

  modport master (input i_q_rd_en, output o_q_valid, output o_q_data, output o_q_count);
  modport slave  (output i_q_rd_en, input o_q_valid, input o_q_data, input o_q_count);
endinterface

// File: rtl/multi_queue_dispatcher_queue.sv
// rtl/multi_queue_dispatcher_queue.sv - show-ahead issue FIFO with flush
module disp_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  // Writes to a full queue and pops of an empty one are dropped here as a second line of defence.
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy bookkeeping; flush behaves like reset for the queue state.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_wr && !do_rd) count_q <= count_q + CW'(1);
      else if (do_rd && !do_wr) count_q <= count_q - CW'(1);
    end
  end
endmodule

// File: rtl/multi_queue_dispatcher.sv
// rtl/multi_queue_dispatcher.sv - decodes the fetch head and steers it into one of four issue queues
module multi_queue_dispatcher
  import multi_queue_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [31:0]               i_fetch_pc_plus_4,
  input  logic [31:0]               i_fetch_instruction,
  input  logic                      i_fetch_empty_flag,
  input  logic                      i_flush,
  output logic                      dispatch_rd_en,
  output logic                      dispatch_jmp_valid,
  output logic [31:0]               dispatch_jmp_br_addr,
  output logic                      o_illegal,
  multi_queue_dispatcher_if.master  q_if
);
  localparam int EW = $bits(disp_entry_t);

  disp_state_t      state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  disp_class_t      cls;
  logic [31:0]      pc;
  logic             is_jal;
  logic [NUM_Q-1:0] q_full, q_empty, q_wr_en;
  disp_entry_t      wr_entry;

  // Decode, dispatch handshake, redirect and next-state computation.
  always_comb begin
    cls                  = decode_class(i_fetch_instruction);
    pc                   = i_fetch_pc_plus_4 - 32'd4;
    is_jal               = (i_fetch_instruction[6:0] == OP_JAL);
    dispatch_rd_en       = (state_q == ST_RUN) & ~i_fetch_empty_flag & ~i_flush &
                           (cls.illegal | ~q_full[cls.q]);
    o_illegal            = dispatch_rd_en & cls.illegal;
    q_wr_en              = (dispatch_rd_en && !cls.illegal) ? (NUM_Q'(1) << cls.q) : '0;
    dispatch_jmp_valid   = dispatch_rd_en & is_jal;
    dispatch_jmp_br_addr = dispatch_jmp_valid ? (pc + jal_imm(i_fetch_instruction)) : 32'd0;
    wr_entry.tag         = TAG_FIELD_W'(tag_q);
    wr_entry.pc          = pc;
    wr_entry.instr       = i_fetch_instruction;
    tag_d                = (dispatch_rd_en && !cls.illegal) ? tag_q + TAG_W'(1) : tag_q;
    state_d              = state_q;
    case (state_q)
      ST_RUN:      if (dispatch_jmp_valid) state_d = ST_JMP_WAIT;
      ST_JMP_WAIT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Dispatch FSM and tag counter; flush returns to RUN but leaves the tag alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      tag_q   <= '0;
    end else if (i_flush) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign q_if.o_q_valid = ~q_empty;

  for (genvar g = 0; g < NUM_Q; g++) begin : g_q
    disp_queue #(.DEPTH(DEPTH), .WIDTH(EW)) u_queue (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .flush_i   (i_flush),
      .wr_en_i   (q_wr_en[g]),
      .wr_data_i (wr_entry),
      .rd_en_i   (q_if.i_q_rd_en[g] & ~i_flush),
      .rd_data_o (q_if.o_q_data[g]),
      .full_o    (q_full[g]),
      .empty_o   (q_empty[g]),
      .count_o   (q_if.o_q_count[g])
    );
  end
endmodule

// File: tb/tb_multi_queue_dispatcher.sv
// tb/tb_multi_queue_dispatcher.sv - directed self-checking bench for multi_queue_dispatcher
module tb_multi_queue_dispatcher;
  import multi_queue_dispatcher_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002080B3;
  localparam logic [31:0] I_MUL  = 32'h022080B3;
  localparam logic [31:0] I_DIV  = 32'h0220C0B3;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_JAL  = 32'h1000006F;
  localparam logic [31:0] I_JALB = 32'hFFDFF06F;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst, flush, empty;
  logic [31:0] instr, pc4;
  logic        rd_en, jmp_valid, illegal;
  logic [31:0] jmp_addr;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  multi_queue_dispatcher_if #(.DEPTH(4)) q_if ();

  multi_queue_dispatcher #(.DEPTH(4), .TAG_W(2)) u_dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_fetch_pc_plus_4    (pc4),
    .i_fetch_instruction  (instr),
    .i_fetch_empty_flag   (empty),
    .i_flush              (flush),
    .dispatch_rd_en       (rd_en),
    .dispatch_jmp_valid   (jmp_valid),
    .dispatch_jmp_br_addr (jmp_addr),
    .o_illegal            (illegal),
    .q_if                 (q_if)
  );

  task automatic check(input string name, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; empty = 1'b1; instr = '0; pc4 = '0;
    q_if.i_q_rd_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd_en", 72'(rd_en), 72'd0);
    check("rst_jmp_valid", 72'(jmp_valid), 72'd0);
    check("rst_jmp_addr", 72'(jmp_addr), 72'd0);
    check("rst_illegal", 72'(illegal), 72'd0);
    check("rst_valid", 72'(q_if.o_q_valid), 72'd0);
    for (int i = 0; i < NUM_Q; i++) check("rst_count", 72'(q_if.o_q_count[i]), 72'd0);

    // Single add into INT
    empty = 1'b0; instr = I_ADD; pc4 = 32'h104;
    #1;
    check("add_rd_en", 72'(rd_en), 72'd1);
    check("add_illegal", 72'(illegal), 72'd0);
    tick();
    empty = 1'b1;
    #1;
    check("add_valid", 72'(q_if.o_q_valid), 72'b0001);
    check("add_data", 72'(q_if.o_q_data[0]), {8'h00, 32'h100, I_ADD});
    check("add_count", 72'(q_if.o_q_count[0]), 72'd1);
    check("idle_rd_en", 72'(rd_en), 72'd0);
    q_if.i_q_rd_en = 4'b0001;
    tick();
    q_if.i_q_rd_en = 4'b0000;
    #1;
    check("int_pop_count", 72'(q_if.o_q_count[0]), 72'd0);

    // Fill MULT (tags 1,2,3,0), 5th mul stalls
    empty = 1'b0; instr = I_MUL; pc4 = 32'h400;
    repeat (4) tick();
    #1;
    check("mult_full_rd_en", 72'(rd_en), 72'd0);
    check("mult_full_count", 72'(q_if.o_q_count[2]), 72'd4);
    check("mult_head", 72'(q_if.o_q_data[2]), {8'h01, 32'h3FC, I_MUL});
    q_if.i_q_rd_en = 4'b0100;
    #1;
    check("mult_pop_same_cycle_rd_en", 72'(rd_en), 72'd0);
    tick();
    q_if.i_q_rd_en = 4'b0000;
    #1;
    check("mult_after_pop_rd_en", 72'(rd_en), 72'd1);
    check("mult_after_pop_count", 72'(q_if.o_q_count[2]), 72'd3);
    check("mult_after_pop_head_tag", 72'(q_if.o_q_data[2].tag), 72'd2);
    tick();
    empty = 1'b1;
    #1;
    check("mult_refill_count", 72'(q_if.o_q_count[2]), 72'd4);
    q_if.i_q_rd_en = 4'b0100;
    repeat (4) tick();
    q_if.i_q_rd_en = 4'b0000;
    #1;
    check("mult_drain_count", 72'(q_if.o_q_count[2]), 72'd0);

    // Forward JAL (tag 2), JMP_WAIT bubble, then add (tag 3)
    empty = 1'b0; instr = I_JAL; pc4 = 32'h204;
    #1;
    check("jal_rd_en", 72'(rd_en), 72'd1);
    check("jal_valid", 72'(jmp_valid), 72'd1);
    check("jal_addr", 72'(jmp_addr), 72'h300);
    tick();
    instr = I_ADD; pc4 = 32'h208;
    #1;
    check("jwait_rd_en", 72'(rd_en), 72'd0);
    check("jwait_jmp_valid", 72'(jmp_valid), 72'd0);
    check("jwait_jmp_addr", 72'(jmp_addr), 72'd0);
    tick();
    #1;
    check("resume_rd_en", 72'(rd_en), 72'd1);
    tick();
    empty = 1'b1;
    #1;
    check("jal_int_count", 72'(q_if.o_q_count[0]), 72'd2);
    check("jal_int_head", 72'(q_if.o_q_data[0]), {8'h02, 32'h200, I_JAL});

    // Backward JAL (tag 0): target = pc - 4
    empty = 1'b0; instr = I_JALB; pc4 = 32'h1008;
    #1;
    check("jalb_valid", 72'(jmp_valid), 72'd1);
    check("jalb_addr", 72'(jmp_addr), 72'h1000);
    tick();
    empty = 1'b1;
    tick();
    #1;
    check("jalb_int_count", 72'(q_if.o_q_count[0]), 72'd3);
    q_if.i_q_rd_en = 4'b0001;
    repeat (3) tick();
    q_if.i_q_rd_en = 4'b0000;

    // Illegal: popped, nothing written, tag stays 1
    empty = 1'b0; instr = I_BAD; pc4 = 32'h500;
    #1;
    check("ill_rd_en", 72'(rd_en), 72'd1);
    check("ill_pulse", 72'(illegal), 72'd1);
    tick();
    instr = I_LW; pc4 = 32'h504;
    #1;
    check("ill_pulse_end", 72'(illegal), 72'd0);
    check("ill_no_write", 72'(q_if.o_q_valid), 72'd0);
    tick();
    empty = 1'b1;
    #1;
    check("ill_tag_held", 72'(q_if.o_q_data[1]), {8'h01, 32'h500, I_LW});
    q_if.i_q_rd_en = 4'b0010;
    tick();
    q_if.i_q_rd_en = 4'b0000;

    // Tag wrap with TAG_W=2 after fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    empty = 1'b0; instr = I_LW; pc4 = 32'h600;
    q_if.i_q_rd_en = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("wrap_tag", 72'(q_if.o_q_data[1].tag), 72'(k % 4));
    end
    empty = 1'b1;
    tick();
    q_if.i_q_rd_en = 4'b0000;
    #1;
    check("wrap_drain_count", 72'(q_if.o_q_count[1]), 72'd0);

    // Flush with div pending: add,add (tags 1,2), div,div (tags 3,0)
    empty = 1'b0; instr = I_ADD; pc4 = 32'h700;
    repeat (2) tick();
    instr = I_DIV;
    repeat (2) tick();
    flush = 1'b1; q_if.i_q_rd_en = 4'b1111;
    #1;
    check("pre_flush_int", 72'(q_if.o_q_count[0]), 72'd2);
    check("pre_flush_div", 72'(q_if.o_q_count[3]), 72'd2);
    check("flush_rd_en", 72'(rd_en), 72'd0);
    tick();
    flush = 1'b0; q_if.i_q_rd_en = 4'b0000;
    #1;
    check("flush_valid", 72'(q_if.o_q_valid), 72'd0);
    check("flush_div_count", 72'(q_if.o_q_count[3]), 72'd0);
    check("post_flush_rd_en", 72'(rd_en), 72'd1);
    tick();
    empty = 1'b1;
    #1;
    check("post_flush_div_count", 72'(q_if.o_q_count[3]), 72'd1);
    check("post_flush_div_head", 72'(q_if.o_q_data[3]), {8'h01, 32'h6FC, I_DIV});

    // Reset during JMP_WAIT with flush also high
    empty = 1'b0; instr = I_JAL; pc4 = 32'h804;
    tick();
    rst = 1'b1; flush = 1'b1; instr = I_ADD;
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    check("rst_jw_valid", 72'(q_if.o_q_valid), 72'd0);
    check("rst_jw_rd_en", 72'(rd_en), 72'd1);
    tick();
    empty = 1'b1;
    #1;
    check("rst_jw_tag", 72'(q_if.o_q_data[0]), {8'h00, 32'h800, I_ADD});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
